// File: rtl/async_fifo_read_port.sv
// rtl/async_fifo_read_port.sv - read-domain half of the async FIFO (optional FIFO_POINTER_CHECK_EN pointer check)
module async_fifo_read_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  destination_clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   write_pointer,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic                  ram_read_enable,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  pointer_error
);

    localparam int LW = ADDR_WIDTH + 2;
    localparam int PW = ADDR_WIDTH + 1;

    logic [1:0]            buf_count;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic                  available;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH:0]   pointer_diff;

    // Issue a RAM read only when the skid buffer can still absorb the returning word.
    always_comb begin
        available    = (write_pointer != read_pointer);
        pop          = out_valid && out_ready;
        occupancy    = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        issue        = available && (occupancy < 3'd2);
        pointer_diff = write_pointer - read_pointer;
    end

    assign ram_read_enable  = issue;
    assign ram_read_address = read_pointer[ADDR_WIDTH-1:0];
    assign out_valid        = (buf_count != 2'd0);
    assign out_data         = buf_head;
    assign empty            = !available && !inflight && (buf_count == 2'd0);
    assign level            = {1'b0, pointer_diff} + LW'(buf_count) + LW'(inflight);

    // Read pointer advances per issued read; inflight marks the word due from RAM next cycle.
    always_ff @(posedge destination_clock or posedge reset) begin
        if (reset) begin
            read_pointer <= '0;
            inflight     <= 1'b0;
        end else begin
            if (issue) begin
                read_pointer <= read_pointer + PW'(1);
            end
            inflight <= issue;
        end
    end

    // Two-entry skid buffer: head is presented, tail catches a word arriving while head is held.
    always_ff @(posedge destination_clock or posedge reset) begin
        if (reset) begin
            buf_count <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
        end else begin
            case ({pop, inflight})
                2'b01: begin
                    if (buf_count == 2'd0) begin
                        buf_head <= ram_read_data;
                    end else begin
                        buf_tail <= ram_read_data;
                    end
                    buf_count <= buf_count + 2'd1;
                end
                2'b10: begin
                    buf_head  <= buf_tail;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= ram_read_data;
                    end else begin
                        buf_head <= ram_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_POINTER_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH = PW'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH:0] previous_write_pointer;
    logic [ADDR_WIDTH:0] write_step;

    assign write_step = write_pointer - previous_write_pointer;

    // Sticky flag: the write pointer jumped by more than DEPTH or ran more than DEPTH ahead.
    always_ff @(posedge destination_clock or posedge reset) begin
        if (reset) begin
            previous_write_pointer <= '0;
            pointer_error          <= 1'b0;
        end else begin
            previous_write_pointer <= write_pointer;
            if ((write_step > DEPTH) || (pointer_diff > DEPTH)) begin
                pointer_error <= 1'b1;
            end
        end
    end
`else
    assign pointer_error = 1'b0;
`endif

endmodule
